// File: rtl/cart_iface_pkg.sv
// rtl/cart_iface_pkg.sv - cartridge bus cycle timing constants and RAM chip-select decode
package cart_iface_pkg;

    typedef enum logic {ST_IDLE, ST_ACTIVE} cyc_state_t;

    localparam int          CYC_LEN      = 8;
    localparam logic [2:0]  LAST_PH      = 3'(CYC_LEN - 1);
    localparam logic [2:0]  CLK_LOW_PH   = 3'd4;
    localparam logic [2:0]  WR_LO_PH     = 3'd4;
    localparam logic [2:0]  WR_HI_PH     = 3'd6;
    localparam logic [2:0]  RD_SAMPLE_PH = 3'd6;
    localparam logic [15:0] RAM_LO       = 16'hA000;
    localparam logic [15:0] RAM_HI       = 16'hFDFF;

    function automatic logic in_ram(input logic [15:0] a);
        return (a >= RAM_LO) && (a <= RAM_HI);
    endfunction

endpackage

// File: rtl/cart_iface.sv
// rtl/cart_iface.sv - converts single-pulse rd/wr requests into 8-clock cartridge bus cycles
module cart_iface (
    input  logic        clk_8m,
    input  logic        rst,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic [15:0] addr,
    input  logic        rd,
    input  logic        wr,
    output logic        busy,
    output logic [15:0] cart_a,
    inout  wire  [7:0]  cart_d,
    output logic        cart_ncs,
    output logic        cart_nrd,
    output logic        cart_nwr,
    output logic        cart_clk,
    output logic        cart_busdir
);
    import cart_iface_pkg::*;

    cyc_state_t state;
    logic [2:0] phase;
    logic [2:0] nxt_ph;
    logic       is_wr;
    logic [7:0] wdata;

    assign nxt_ph = phase + 3'd1;

    // The data bus is driven exactly while the level shifter points toward the cartridge.
    assign cart_d = cart_busdir ? wdata : 8'hzz;

    // Outputs are registered with the value of the phase being entered, so they line up with p.
    always_ff @(posedge clk_8m or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            phase       <= '0;
            is_wr       <= 1'b0;
            wdata       <= '0;
            dout        <= '0;
            busy        <= 1'b0;
            cart_a      <= '0;
            cart_ncs    <= 1'b1;
            cart_nrd    <= 1'b1;
            cart_nwr    <= 1'b1;
            cart_clk    <= 1'b0;
            cart_busdir <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (rd || wr) begin
                state    <= ST_ACTIVE;
                phase    <= '0;
                busy     <= 1'b1;
                is_wr    <= wr;
                wdata    <= din;
                cart_a   <= addr;
                cart_ncs <= !in_ram(addr);
                cart_clk <= 1'b1;
                cart_nrd <= wr;
            end
        end else begin
            if (phase == LAST_PH) begin
                state       <= ST_IDLE;
                busy        <= 1'b0;
                cart_ncs    <= 1'b1;
                cart_nrd    <= 1'b1;
                cart_nwr    <= 1'b1;
                cart_clk    <= 1'b0;
                cart_busdir <= 1'b0;
            end else begin
                phase       <= nxt_ph;
                cart_clk    <= nxt_ph < CLK_LOW_PH;
                cart_busdir <= is_wr;
                cart_nwr    <= !(is_wr && (nxt_ph >= WR_LO_PH) && (nxt_ph <= WR_HI_PH));
                if (!is_wr && (phase == RD_SAMPLE_PH))
                    dout <= cart_d;
            end
        end
    end

endmodule

// File: tb/tb_cart_iface.sv
// tb/tb_cart_iface.sv - randomized self-checking bench for cart_iface against a phase-rule model
`timescale 1ns/1ps
module tb_cart_iface;

    logic        clk_8m = 1'b0;
    logic        rst    = 1'b0;
    logic [7:0]  din    = '0;
    logic [15:0] addr   = '0;
    logic        rd     = 1'b0;
    logic        wr     = 1'b0;
    logic [7:0]  dout;
    logic        busy;
    logic [15:0] cart_a;
    wire  [7:0]  cart_d;
    logic        cart_ncs, cart_nrd, cart_nwr, cart_clk, cart_busdir;
    logic [7:0]  cart_drv = '0;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_dout = '0;
    logic [37:0] cap [0:8];

    cart_iface dut (
        .clk_8m(clk_8m), .rst(rst), .din(din), .dout(dout), .addr(addr),
        .rd(rd), .wr(wr), .busy(busy), .cart_a(cart_a), .cart_d(cart_d),
        .cart_ncs(cart_ncs), .cart_nrd(cart_nrd), .cart_nwr(cart_nwr),
        .cart_clk(cart_clk), .cart_busdir(cart_busdir)
    );

    // Cartridge answers a read only while the shifter points at the FPGA and the read strobe is low.
    assign cart_d = (!cart_busdir && !cart_nrd) ? cart_drv : 8'hzz;

    always #62.5 clk_8m = ~clk_8m;

    wire [37:0] obs_now = {busy, cart_a, cart_ncs, cart_clk, cart_nrd, cart_nwr,
                           cart_busdir, cart_d, dout};

    // k = clocks since acceptance (0..7 active, 8 = idle after the cycle).
    function automatic logic [37:0] model(input bit w, input logic [15:0] a, input logic [7:0] d,
                                          input logic [7:0] cd, input int k, input logic [7:0] prev);
        bit act = (k < 8);
        bit ram = (a >= 16'hA000) && (a <= 16'hFDFF);
        bit bd  = act && w && (k >= 1);
        return {act, a, !(act && ram), act && (k < 4), !(act && !w),
                !(act && w && (k >= 4) && (k <= 6)), bd, (bd ? d : 8'h00),
                ((!w && k >= 7) ? cd : prev)};
    endfunction

    function automatic logic [37:0] mask(input bit w, input int k);
        return (w && k >= 1 && k <= 7) ? {38{1'b1}} : 38'h3FFFFF00FF;
    endfunction

    task automatic run_cycle(input logic r, input logic w, input logic [15:0] a,
                             input logic [7:0] d, input logic [7:0] cd, input int rd_at);
        addr = a; din = d; rd = r; wr = w; cart_drv = cd;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk_8m);
            cap[k] = obs_now;
            if (k == 0) begin
                rd = 1'b0; wr = 1'b0;
                addr = 16'($urandom); din = 8'($urandom);
            end
            if (k == rd_at) rd = 1'b1;
            else if (k == rd_at + 1) rd = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [37:0] e, m;
        rst = 1'b0;
        repeat (3) @(negedge clk_8m);
        e = model(1'b0, 16'h0000, 8'h00, 8'h00, 8, 8'h00);
        m = mask(1'b0, 8);
        checks++;
        if ((obs_now & m) !== (e & m)) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs_now & m, e & m);
        end
        rst = 1'b1;
        model_dout = 8'h00;
        @(negedge clk_8m);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_read(input logic [15:0] a, input logic [7:0] cd);
        logic [37:0] e, m;
        int nbusy = 0;
        run_cycle(1'b1, 1'b0, a, 8'h00, cd, -1);
        for (int k = 0; k < 9; k++) begin
            e = model(1'b0, a, 8'h00, cd, k, model_dout);
            m = mask(1'b0, k);
            nbusy += int'(cap[k][37]);
            checks++;
            if ((cap[k] & m) !== (e & m)) begin
                errors++;
                $display("FAIL read_%h phase %0d: got %h expected %h", a, k, cap[k] & m, e & m);
            end
        end
        checks++;
        if (nbusy != 8) begin
            errors++;
            $display("FAIL read_%h_busy_len: got %0d expected 8", a, nbusy);
        end
        model_dout = cd;
    endtask

    task automatic test_write;
        logic [37:0] e, m;
        int nlow = 0;
        run_cycle(1'b0, 1'b1, 16'hA5A5, 8'hA5, 8'h00, -1);
        for (int k = 0; k < 9; k++) begin
            e = model(1'b1, 16'hA5A5, 8'hA5, 8'h00, k, model_dout);
            m = mask(1'b1, k);
            nlow += int'(!cap[k][17]);
            checks++;
            if ((cap[k] & m) !== (e & m)) begin
                errors++;
                $display("FAIL write_a5a5 phase %0d: got %h expected %h", k, cap[k] & m, e & m);
            end
        end
        checks++;
        if (nlow != 3) begin
            errors++;
            $display("FAIL write_nwr_len: got %0d expected 3", nlow);
        end
    endtask

    task automatic test_ignore_and_both;
        logic [37:0] e, m;
        run_cycle(1'b0, 1'b1, 16'hC000, 8'h3C, 8'h11, 3);
        for (int k = 0; k < 9; k++) begin
            e = model(1'b1, 16'hC000, 8'h3C, 8'h11, k, model_dout);
            m = mask(1'b1, k);
            checks++;
            if ((cap[k] & m) !== (e & m)) begin
                errors++;
                $display("FAIL midcycle_rd phase %0d: got %h expected %h", k, cap[k] & m, e & m);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_8m);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL midcycle_rd_queued: busy got %b expected 0", busy);
            end
        end
        run_cycle(1'b1, 1'b1, 16'hB000, 8'h5A, 8'h22, -1);
        for (int k = 0; k < 9; k++) begin
            e = model(1'b1, 16'hB000, 8'h5A, 8'h22, k, model_dout);
            m = mask(1'b1, k);
            checks++;
            if ((cap[k] & m) !== (e & m)) begin
                errors++;
                $display("FAIL rd_wr_both phase %0d: got %h expected %h", k, cap[k] & m, e & m);
            end
        end
    endtask

    task automatic test_reset_mid_write;
        addr = 16'hA123; din = 8'h77; wr = 1'b1;
        @(negedge clk_8m);
        wr = 1'b0;
        repeat (5) @(negedge clk_8m);
        checks++;
        if ({busy, cart_nwr, cart_busdir} !== 3'b101) begin
            errors++;
            $display("FAIL pre_reset_p5: busy/nwr/busdir got %b expected 101",
                     {busy, cart_nwr, cart_busdir});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, cart_nwr, cart_busdir, cart_ncs, cart_clk, cart_nrd, dout} !== {6'b010101, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid_write: got %b expected %b",
                     {busy, cart_nwr, cart_busdir, cart_ncs, cart_clk, cart_nrd, dout}, {6'b010101, 8'h00});
        end
        model_dout = 8'h00;
        @(negedge clk_8m);
        rst = 1'b1;
        @(negedge clk_8m);
        test_read(16'hA800, 8'h99);
    endtask

    task automatic test_back_to_back;
        logic [37:0] e, m;
        logic [15:0] a;
        logic [7:0]  d, cd;
        bit          w, both;
        for (int i = 0; i < 24; i++) begin
            w    = 1'($urandom_range(0, 1));
            both = w && ($urandom_range(0, 3) == 0);
            d    = 8'($urandom);
            cd   = 8'($urandom);
            case ($urandom_range(0, 4))
                0:       a = 16'h9FFF;
                1:       a = 16'hA000;
                2:       a = 16'hFDFF;
                3:       a = 16'hFE00;
                default: a = 16'($urandom);
            endcase
            run_cycle(!w || both, w, a, d, cd, -1);
            for (int k = 0; k < 9; k++) begin
                e = model(w, a, d, cd, k, model_dout);
                m = mask(w, k);
                checks++;
                if ((cap[k] & m) !== (e & m)) begin
                    errors++;
                    $display("FAIL b2b_%0d_%s_%h phase %0d: got %h expected %h",
                             i, w ? "wr" : "rd", a, k, cap[k] & m, e & m);
                end
            end
            if (!w) model_dout = cd;
        end
    endtask

    initial begin
        test_reset;
        test_read(16'hAA55, 8'hAA);
        test_read(16'h1234, 8'hAA);
        test_write;
        test_ignore_and_both;
        test_reset_mid_write;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
